// File: rtl/truth_table_scanner.sv
// Walks every input vector of a small Boolean block, samples its output at the end
// of each hold window, and scores the captured truth table against an expected one.
module truth_table_scanner #(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [(1<<N_IN)-1:0]     expected,
    output logic [N_IN-1:0]          vec_out,
    input  logic                     d_in,
    output logic                     busy,
    output logic                     done,
    output logic [(1<<N_IN)-1:0]     table_out,
    output logic                     pass,
    output logic [N_IN:0]            mismatch_cnt,
    output logic [N_IN-1:0]          first_fail,
    output logic                     fail_valid
);

    // state  | meaning
    // IDLE   | vec_out parked at 0, results held, waiting for start
    // DRIVE  | presenting vec_out, sampling d_in on the last hold clock
    // DONE   | single-cycle completion pulse, pass valid
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int NV = 1 << N_IN;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [NV-1:0]     exp_q, exp_d;
    logic [NV-1:0]     table_q, table_d;
    logic [N_IN:0]     mcnt_q, mcnt_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              fv_q, fv_d;
    logic              pass_q, pass_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            exp_q   <= '0;
            table_q <= '0;
            mcnt_q  <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            mcnt_q  <= mcnt_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        exp_d   = exp_q;
        table_d = table_q;
        mcnt_d  = mcnt_q;
        ff_d    = ff_q;
        fv_d    = fv_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                vec_d = '0;
                if (start) begin
                    exp_d   = expected;
                    table_d = '0;
                    mcnt_d  = '0;
                    ff_d    = '0;
                    fv_d    = 1'b0;
                    pass_d  = 1'b0;
                    hold_d  = '0;
                    state_d = S_DRIVE;
                end
            end

            S_DRIVE: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) begin
                    hold_d         = '0;
                    table_d[vec_q] = d_in;
                    if (d_in != exp_q[vec_q]) begin
                        mcnt_d = mcnt_q + 1'b1;
                        if (!fv_q) begin
                            ff_d = vec_q;
                            fv_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        // pass must already be valid in the DONE cycle, so it is
                        // computed from the count including this final sample
                        pass_d  = (mcnt_d == '0);
                        state_d = S_DONE;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end

            S_DONE: begin
                vec_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                vec_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign vec_out      = vec_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign table_out    = table_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mcnt_q;
    assign first_fail   = ff_q;
    assign fail_valid   = fv_q;

endmodule
